// File: rtl/serial_addsub_8bit_if.sv
// serial_addsub_8bit_if
//   Request/result bundle for the bit-serial adder/subtractor.
//   master: drives start, sub, a, b; observes busy, done and the results.
//   slave : the arithmetic block.
//   Signals:
//     start, sub, a, b  - operation request, sampled when start=1 at an edge
//     busy, done        - operation in progress / one-cycle result-valid pulse
//     sum, cout, out    - result, carry (no-borrow on subtract), {cout, sum}
//     ovf, zero         - signed overflow, sum == 0
interface serial_addsub_8bit_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH:0]   out;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, out, ovf, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, out, ovf, zero
    );
endinterface

// File: rtl/serial_addsub_8bit.sv
// serial_addsub_8bit
//   Bit-serial unsigned adder/subtractor, one bit per clock, LSB first.
//   An operation latched at edge E0 produces its result on edge E(WIDTH);
//   done is high for the following cycle.
//   Ports:
//     clk - clock, all state changes on the rising edge
//     rst - synchronous active-high reset, takes priority over start
//     bus - serial_addsub_8bit_if.slave (request + result signals)
module serial_addsub_8bit #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_addsub_8bit_if.slave  bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;

    logic             bit_s;
    logic             carry_n;
    logic [WIDTH-1:0] res_n;

    // One full-adder slice; res_n is the result register after this bit.
    always_comb begin
        bit_s   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_n = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        res_n   = {bit_s, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Subtract as a + ~b + 1: the +1 enters via the carry.
                        a_sr   <= bus.a;
                        b_sr   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_n;
                    carry  <= carry_n;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here.
                        sum_r  <= res_n;
                        cout_r <= carry_n;
                        ovf_r  <= carry ^ carry_n;
                        zero_r <= (res_n == '0);
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.out  = {cout_r, sum_r};
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;
endmodule

// File: tb/tb_serial_addsub_8bit.sv
// tb_serial_addsub_8bit
//   Self-checking bench for serial_addsub_8bit (WIDTH=8). Inputs change and
//   outputs are sampled on the falling edge. Expected results come from
//   plain integer arithmetic on the operands.
module tb_serial_addsub_8bit;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_addsub_8bit_if #(.WIDTH(W)) bus ();

    serial_addsub_8bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Launch one operation at the current falling edge, wait (bounded) for
    // done, then compare latency, busy length and all result outputs
    // against integer arithmetic. Operand inputs are scrambled once latched.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input string tag);
        int          ia, ib, sa, sb, sr, r;
        logic [W-1:0] es;
        logic        ec, eo, ez;
        int          k, busy_cycles;
        logic        got;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 2**(W-1)) ? ia - 2**W : ia;
        sb = (ib >= 2**(W-1)) ? ib - 2**W : ib;
        if (sub) begin
            r  = ia - ib;
            ec = (ia >= ib);
            sr = sa - sb;
        end else begin
            r  = ia + ib;
            ec = (r >= 2**W);
            sr = sa + sb;
        end
        es = W'((r % (2**W) + 2**W) % (2**W));
        eo = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
        ez = (es == '0);

        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        k = 0;
        busy_cycles = 0;
        got = 1'b0;
        while (!got && k < W + 6) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.sub   = 1'($urandom);
            end
            if (bus.busy) busy_cycles++;
            if (bus.done) got = 1'b1;
        end
        checks++;
        if (!got || k !== W + 1)
            begin errors++; $display("FAIL %s latency: got=%0d done=%0b want=%0d", tag, k, got, W + 1); end
        checks++;
        if (busy_cycles !== W)
            begin errors++; $display("FAIL %s busy_cycles: got=%0d want=%0d", tag, busy_cycles, W); end
        checks++;
        if (bus.sum !== es)
            begin errors++; $display("FAIL %s sum: got=%0d want=%0d", tag, bus.sum, es); end
        checks++;
        if (bus.cout !== ec)
            begin errors++; $display("FAIL %s cout: got=%0b want=%0b", tag, bus.cout, ec); end
        checks++;
        if (bus.out !== {ec, es})
            begin errors++; $display("FAIL %s out: got=%0d want=%0d", tag, bus.out, {ec, es}); end
        checks++;
        if (bus.ovf !== eo)
            begin errors++; $display("FAIL %s ovf: got=%0b want=%0b", tag, bus.ovf, eo); end
        checks++;
        if (bus.zero !== ez)
            begin errors++; $display("FAIL %s zero: got=%0b want=%0b", tag, bus.zero, ez); end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;   // reset must win over start
        bus.sub   = 1'b0;
        bus.a     = 8'd3;
        bus.b     = 8'd4;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL reset busy/done: got=%0b/%0b want=0/0", bus.busy, bus.done); end
        checks++;
        if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.out !== '0 || bus.ovf !== 1'b0)
            begin errors++; $display("FAIL reset results: sum=%0d cout=%0b out=%0d ovf=%0b want all 0", bus.sum, bus.cout, bus.out, bus.ovf); end
        checks++;
        if (bus.zero !== 1'b1)
            begin errors++; $display("FAIL reset zero: got=%0b want=1", bus.zero); end
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0)
            begin errors++; $display("FAIL reset idle busy: got=%0b want=0", bus.busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] held;
        run_op(8'd10,  8'd20,  1'b0, "add_10_20");
        held = bus.sum;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sum !== 8'd30 || bus.done !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL hold: sum=%0d done=%0b busy=%0b want 30/0/0 (was %0d)", bus.sum, bus.done, bus.busy, held); end
        run_op(8'd255, 8'd255, 1'b0, "add_255_255");
        @(negedge clk);
        run_op(8'd127, 8'd127, 1'b0, "add_127_127");
        @(negedge clk);
        run_op(8'd5,   8'd0,   1'b1, "sub_5_0");
        @(negedge clk);
        run_op(8'd10,  8'd20,  1'b1, "sub_10_20");
        @(negedge clk);
        run_op(8'd99,  8'd99,  1'b1, "sub_99_99");
        @(negedge clk);
        run_op(8'd128, 8'd1,   1'b1, "sub_128_1");
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int   k;
        logic got;
        bus.start = 1'b1; bus.a = 8'd10; bus.b = 8'd20; bus.sub = 1'b0;
        k = 0;
        got = 1'b0;
        while (!got && k < W + 6) begin
            @(negedge clk);
            k++;
            if (k == 1) bus.start = 1'b0;
            if (k == 3) begin bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1; bus.sub = 1'b1; end
            if (k == 4) begin
                bus.start = 1'b0;
                checks++;
                if (bus.busy !== 1'b1)
                    begin errors++; $display("FAIL ignore busy: got=%0b want=1", bus.busy); end
            end
            if (bus.done) got = 1'b1;
        end
        checks++;
        if (!got || k !== W + 1)
            begin errors++; $display("FAIL ignore latency: got=%0d done=%0b want=%0d", k, got, W + 1); end
        checks++;
        if (bus.sum !== 8'd30 || bus.cout !== 1'b0)
            begin errors++; $display("FAIL ignore result: sum=%0d cout=%0b want 30/0", bus.sum, bus.cout); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_op(8'd14, 8'd1, 1'b0, "b2b_first");
        // Still inside the done cycle: the next run_op raises start here.
        run_op(8'd5,  8'd0, 1'b1, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.start = 1'b1; bus.a = 8'd99; bus.b = 8'd23; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;         // 4th RUN cycle
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL midrst busy/done: got=%0b/%0b want=0/0", bus.busy, bus.done); end
        checks++;
        if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.out !== '0 || bus.ovf !== 1'b0 || bus.zero !== 1'b1)
            begin errors++; $display("FAIL midrst results: sum=%0d cout=%0b out=%0d ovf=%0b zero=%0b want 0/0/0/0/1", bus.sum, bus.cout, bus.out, bus.ovf, bus.zero); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0)
            begin errors++; $display("FAIL midrst aborted: activity=%0b want=0", seen); end
        run_op(8'd99, 8'd23, 1'b0, "after_rst_99_23");
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_addsub_8bit.md
SERIAL_ADDSUB_8BIT -- requirements
Module: serial_addsub_8bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (supported range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on the rising edge only.
REQ-003 The block SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin an operation, sampled on each rising edge.
REQ-005 The block SHALL have port sub, input, 1, the operation select sampled with start: 0 = add (a+b), 1 = subtract (a-b).
REQ-006 The block SHALL have ports a and b, input, WIDTH each, the unsigned operands sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking results valid.
REQ-009 The block SHALL have port sum, output, WIDTH, the result (sum or difference, modulo 2^WIDTH).
REQ-010 The block SHALL have port cout, output, 1: the carry-out when adding; the no-borrow flag (1 when a >= b) when subtracting.
REQ-011 The block SHALL have port out, output, WIDTH+1, equal to {cout, sum}.
REQ-012 The block SHALL have port ovf, output, 1, the two's-complement signed overflow of the operation.
REQ-013 The block SHALL have port zero, output, 1, high when sum == 0.

Function
REQ-014 The block SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL latch a, b and sub into internal shift registers, clear the bit counter, and enter RUN.
REQ-016 On latch, the carry flop SHALL be set to sub, and the b register SHALL hold ~b when sub=1 and b when sub=0.
REQ-017 In RUN, each edge SHALL process one bit, LSB first, using a 1-bit full adder: sum bit = a0^b0^c, next carry = majority(a0, b0, c).
REQ-018 In RUN, each edge SHALL also shift the operand registers right by one and shift the sum bit into the MSB of the result shift register.
REQ-019 The bit counter SHALL increment once per RUN edge; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-020 On that same edge, sum, cout, out, ovf and zero SHALL update; ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 Latency: with start sampled at edge E0, done SHALL be high during the cycle after edge E(WIDTH), i.e. results are valid WIDTH cycles after start.
REQ-022 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-023 DONE SHALL last one cycle and then go to IDLE, or to RUN if start=1 in that cycle, giving back-to-back operation with no idle gap.
REQ-024 start while busy=1 SHALL be ignored: operands are not re-latched and the operation in progress is unaffected.
REQ-025 sum, cout, out, ovf and zero SHALL hold their last results through IDLE and RUN until the next DONE overwrites them.
REQ-026 Changes on a, b or sub after the latch edge SHALL NOT affect the operation in progress.

Reset
REQ-027 While rst=1 at an edge, the FSM SHALL enter IDLE and busy, done, sum, cout, out and ovf SHALL be set to 0.
REQ-028 After reset, zero SHALL be 1, consistent with sum == 0.
REQ-029 Internal shift registers, the carry flop and the counter SHALL clear on reset.
REQ-030 rst SHALL take priority over start.
REQ-031 rst asserted mid-RUN SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL operate normally.

Verification (WIDTH=8)
REQ-032 Add a=10, b=20 -> done exactly 8 cycles after the start edge; sum=30, cout=0, out=30, ovf=0, zero=0; busy high for exactly 8 cycles.
REQ-033 Add a=255, b=255 -> sum=254, cout=1, out=510, ovf=0; add a=127, b=127 -> sum=254, cout=0, ovf=1.
REQ-034 Subtract a=5, b=0 -> sum=5, cout=1, ovf=0; subtract a=10, b=20 -> sum=246, cout=0, out=246; subtract a=99, b=99 -> sum=0, zero=1, cout=1.
REQ-035 Start 10+20, then pulse start with a=1, b=1 during RUN -> the second start is ignored and the result is still 30.
REQ-036 Back-to-back: start=1 during done of 14+1 (result 15) with operands 5-0 latched -> done again 8 cycles later with sum=5, and no IDLE cycle in between.
REQ-037 Assert rst at the 4th RUN cycle of 99+23 -> no done pulse; all outputs return to reset values; a following 99+23 -> sum=122, cout=0.
